hex_scan_display: RTL and testbench

Parametrised successor to the single-digit combinational hex decoder. It drives NUM_DIGITS seven-segment digits over one shared segment bus and time-multiplexes them with a per-digit enable line. Values are loaded through a tear-free shadow register that commits only at frame boundaries. It adds leading-zero blanking, per-digit blinking and a selectable output polarity. The block sits between datapath registers and the board's segment and digit-enable pins.

---
 rtl/hex_scan_display.sv | 203 ++++++++++++++++++++
 tb/tb_hex_scan_display.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_display.sv
// hex_scan_display: time-multiplexed seven-segment driver for NUM_DIGITS
// hex digits with frame-aligned shadow commit, leading-zero blanking and blink.
module hex_scan_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_sel,
  output logic                    pend,
  output logic                    upd
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] SEL_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_FRAMES - 1);

  // "All segments off" / "all digits off" depend on pin polarity.
  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};

  logic [PS_W-1:0]       r_presc;
  logic [IDX_W-1:0]      r_sel;
  logic [FR_W-1:0]       r_frame;
  logic                  r_blink;
  logic [VAL_W-1:0]      r_pending;
  logic                  r_pend;
  logic [VAL_W-1:0]      r_shadow;
  logic                  r_upd;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  logic                  w_tick;
  logic                  w_frame_end;
  logic [NUM_DIGITS-1:0] w_hiz;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [3:0]            w_nib;
  logic                  w_lz;
  logic                  w_bm;
  logic                  w_blank;
  logic [6:0]            w_glyph;
  logic [6:0]            w_seg_next;
  logic [NUM_DIGITS-1:0] w_an_next;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] f_glyph(input logic [3:0] n);
    logic [6:0] g;
    g = 7'h00;
    unique case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
    endcase
    return g;
  endfunction

  assign w_tick      = (r_presc == PS_LAST);
  assign w_frame_end = w_tick & (r_sel == SEL_LAST);

  // Prescaler: one tick every SCAN_DIV clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PS_W'(1);
    end
  end

  // Digit index advances on each tick and wraps after the last digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel <= '0;
    end else if (w_tick) begin
      if (r_sel == SEL_LAST) begin
        r_sel <= '0;
      end else begin
        r_sel <= r_sel + IDX_W'(1);
      end
    end
  end

  // Frame counter and blink phase; phase flips every BLINK_FRAMES frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame <= '0;
      r_blink <= 1'b0;
    end else if (w_frame_end) begin
      if (r_frame == FR_LAST) begin
        r_frame <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_frame <= r_frame + FR_W'(1);
      end
    end
  end

  // Load capture and frame-boundary commit; a load landing on the
  // frame boundary bypasses the pending register entirely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_pend    <= 1'b0;
      r_shadow  <= '0;
      r_upd     <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (w_frame_end && load) begin
        r_shadow <= value_in;
        r_pend   <= 1'b0;
        r_upd    <= 1'b1;
      end else if (w_frame_end && r_pend) begin
        r_shadow <= r_pending;
        r_pend   <= 1'b0;
        r_upd    <= 1'b1;
      end else if (load) begin
        r_pending <= value_in;
        r_pend    <= 1'b1;
      end
    end
  end

  // w_hiz[i]: shadow nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    w_hiz = '0;
    w_hiz[NUM_DIGITS-1] = (r_shadow[VAL_W-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_hiz[i] = w_hiz[i+1] & (r_shadow[4*i +: 4] == 4'h0);
    end
  end

  // Select the current digit's nibble and its blanking inputs.
  always_comb begin
    w_nib    = 4'h0;
    w_lz     = 1'b0;
    w_bm     = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_sel == IDX_W'(i)) begin
        w_nib       = r_shadow[4*i +: 4];
        w_lz        = (i > 0) && w_hiz[i];
        w_bm        = blink_mask[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_blank   = (blank_lz & w_lz) | (w_bm & r_blink);
  assign w_glyph   = f_glyph(w_nib);
  assign w_an_next = ACTIVE_LOW ? ~w_onehot : w_onehot;

  always_comb begin
    w_seg_next = ACTIVE_LOW ? ~w_glyph : w_glyph;
    if (w_blank) begin
      w_seg_next = SEG_OFF;
    end
  end

  // Pin registers: follow digit_sel one clock later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  assign seg       = r_seg;
  assign an        = r_an;
  assign digit_sel = r_sel;
  assign pend      = r_pend;
  assign upd       = r_upd;

endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display: random load/blank/blink stimulus on two configurations,
// compared each clock against a cycle-count based reference model.
module tb_hex_scan_display;

  localparam int NA = 4, SA = 4, BA = 2;
  localparam int NB = 3, SB = 3, BB = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [31:0] val = '0;
  logic [7:0]  mask = '0;

  logic [6:0]    seg_a, seg_b;
  logic [NA-1:0] an_a;
  logic [NB-1:0] an_b;
  logic [1:0]    sel_a, sel_b;
  logic          pend_a, pend_b, upd_a, upd_b;

  int checks = 0;
  int errors = 0;

  int nd [2] = '{NA, NB};
  int sd [2] = '{SA, SB};
  int bf [2] = '{BA, BB};
  bit al [2] = '{1'b1, 1'b0};

  logic [6:0] glyph [16];

  int          m_c   [2];
  logic [31:0] m_sh  [2];
  logic [31:0] m_pn  [2];
  bit          m_pd  [2];
  logic [31:0] e_seg [2];
  logic [31:0] e_an  [2];
  logic [31:0] e_sel [2];
  bit          e_upd [2];

  logic [31:0] dir_vals [$];

  always #5 clk = ~clk;

  hex_scan_display #(
    .NUM_DIGITS(NA), .SCAN_DIV(SA),
    .BLINK_FRAMES(BA), .ACTIVE_LOW(1'b1)
  ) u_a (
    .clk(clk), .reset(reset),
    .value_in(val[4*NA-1:0]), .load(load),
    .blank_lz(blank_lz), .blink_mask(mask[NA-1:0]),
    .seg(seg_a), .an(an_a), .digit_sel(sel_a),
    .pend(pend_a), .upd(upd_a)
  );

  hex_scan_display #(
    .NUM_DIGITS(NB), .SCAN_DIV(SB),
    .BLINK_FRAMES(BB), .ACTIVE_LOW(1'b0)
  ) u_b (
    .clk(clk), .reset(reset),
    .value_in(val[4*NB-1:0]), .load(load),
    .blank_lz(blank_lz), .blink_mask(mask[NB-1:0]),
    .seg(seg_b), .an(an_b), .digit_sel(sel_b),
    .pend(pend_b), .upd(upd_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_c[k]   = 0;
      m_sh[k]  = '0;
      m_pn[k]  = '0;
      m_pd[k]  = 1'b0;
      e_seg[k] = al[k] ? 32'h7F : 32'h00;
      e_an[k]  = al[k] ? ((32'h1 << nd[k]) - 1) : 32'h0;
      e_sel[k] = '0;
      e_upd[k] = 1'b0;
    end
  endtask

  // One clock edge: display is a function of elapsed cycles since reset.
  task automatic step(input int k);
    int          n, c, sel, frames, ph;
    logic [31:0] vm, hi, v, oh;
    logic [6:0]  g, s;
    bit          blank, fe;
    n      = nd[k];
    c      = m_c[k];
    vm     = (32'h1 << (4 * n)) - 1;
    sel    = (c / sd[k]) % n;
    frames = c / (sd[k] * n);
    ph     = (frames / bf[k]) % 2;
    hi     = m_sh[k] >> (4 * sel);
    blank  = (blank_lz && sel > 0 && hi == 0) ||
             (mask[sel] && ph == 1);
    g      = blank ? 7'h00 : glyph[hi[3:0]];
    s      = al[k] ? ~g : g;
    e_seg[k] = 32'(s);
    oh     = 32'h1 << sel;
    e_an[k] = al[k] ? (~oh & ((32'h1 << n) - 1)) : oh;
    fe     = ((c + 1) % (sd[k] * n)) == 0;
    v      = val & vm;
    e_upd[k] = 1'b0;
    if (fe && load) begin
      m_sh[k]  = v;
      m_pd[k]  = 1'b0;
      e_upd[k] = 1'b1;
    end else if (fe && m_pd[k]) begin
      m_sh[k]  = m_pn[k];
      m_pd[k]  = 1'b0;
      e_upd[k] = 1'b1;
    end else if (load) begin
      m_pn[k] = v;
      m_pd[k] = 1'b1;
    end
    e_sel[k] = ((c + 1) / sd[k]) % n;
    m_c[k]   = c + 1;
  endtask

  task automatic check_all();
    check("a.seg",  32'(seg_a),  e_seg[0]);
    check("a.an",   32'(an_a),   e_an[0]);
    check("a.sel",  32'(sel_a),  e_sel[0]);
    check("a.pend", 32'(pend_a), 32'(m_pd[0]));
    check("a.upd",  32'(upd_a),  32'(e_upd[0]));
    check("b.seg",  32'(seg_b),  e_seg[1]);
    check("b.an",   32'(an_b),   e_an[1]);
    check("b.sel",  32'(sel_b),  e_sel[1]);
    check("b.pend", 32'(pend_b), 32'(m_pd[1]));
    check("b.upd",  32'(upd_b),  32'(e_upd[1]));
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        r[4*i +: 4] = 4'($urandom_range(1, 15));
      end
    end
    return r;
  endfunction

  initial begin
    int rst_left;
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    dir_vals = '{32'h1A2F, 32'h0050, 32'h0000, 32'h1111, 32'h2222};
    model_reset();
    rst_left = 3;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      load = 1'b0;
      if (rst_left == 0 &&
          ($urandom_range(0, 499) == 0 || cyc == 1500 || cyc == 3000)) begin
        rst_left = $urandom_range(1, 3);
      end
      if (rst_left > 0) begin
        reset = 1'b1;
        rst_left--;
      end else begin
        reset = 1'b0;
        if ($urandom_range(0, 8) == 0 || cyc == 1499 || cyc == 2999) begin
          load = 1'b1;
          if (dir_vals.size() > 0) val = dir_vals.pop_front();
          else val = rand_val();
        end
        if ($urandom_range(0, 59) == 0) blank_lz = ~blank_lz;
        if ($urandom_range(0, 79) == 0) mask = 8'($urandom());
      end
      if (reset) begin
        model_reset();
        #1;
        check_all();
      end
      @(posedge clk);
      if (!reset) begin
        step(0);
        step(1);
      end
      #1;
      check_all();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
